// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one downstream 4-phase handshake target among N
// upstream 4-phase requesters. All outputs are registered.
module hs_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  up_req,
  output logic [N-1:0]  up_ack,
  output logic          dn_req,
  input  logic          dn_ack,
  output logic [IW-1:0] grant_id,
  output logic          busy,
  output logic          proto_err
);

  typedef enum logic [1:0] {StIdle, StReq, StAck, StRtz} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [N-1:0]  up_ack_q, up_ack_d;
  logic          dn_req_q, dn_req_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [IW-1:0] winner;
  logic          found;
  logic [IW-1:0] gnt_next;

  // First set request bit at or above ptr, wrapping modulo N.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned idx;
      idx = ptr_q + i;
      if (idx >= N) idx = idx - N;
      if (!found && up_req[IW'(idx)]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign gnt_next = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    up_ack_d = up_ack_q;
    dn_req_d = dn_req_q;
    busy_d   = busy_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (dn_ack) err_d = 1'b1;
        if (found) begin
          state_d  = StReq;
          gnt_d    = winner;
          dn_req_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      StReq: begin
        // A withdrawn request is flagged but the downstream handshake still completes.
        if (!up_req[gnt_q]) err_d = 1'b1;
        if (dn_ack) begin
          state_d         = StAck;
          up_ack_d        = '0;
          up_ack_d[gnt_q] = 1'b1;
        end
      end
      StAck: begin
        if (!dn_ack) err_d = 1'b1;
        if (!up_req[gnt_q]) begin
          state_d  = StRtz;
          dn_req_d = 1'b0;
        end
      end
      StRtz: begin
        if (!dn_ack) begin
          state_d  = StIdle;
          up_ack_d = '0;
          busy_d   = 1'b0;
          ptr_d    = gnt_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      gnt_q    <= '0;
      up_ack_q <= '0;
      dn_req_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      up_ack_q <= up_ack_d;
      dn_req_q <= dn_req_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign up_ack    = up_ack_q;
  assign dn_req    = dn_req_q;
  assign grant_id  = gnt_q;
  assign busy      = busy_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed bench for hs_rr_arbiter (N=4): handshake timing, round-robin order,
// protocol-error flagging and mid-transaction reset.
module tb_hs_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  up_req;
  logic [N-1:0]  up_ack;
  logic          dn_req;
  logic          dn_ack;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          proto_err;

  int errors = 0;
  int checks = 0;

  hs_rr_arbiter #(.N(N), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .up_req   (up_req),
    .up_ack   (up_ack),
    .dn_req   (dn_req),
    .dn_ack   (dn_ack),
    .grant_id (grant_id),
    .busy     (busy),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    up_req = '0;
    dn_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // One transaction with zero-latency peers; req is the full request vector.
  task automatic run_txn(input logic [N-1:0] req, input int g, input string tag);
    logic [31:0] exp_ack;
    exp_ack = 32'd1 << g;
    up_req  = req;
    tick();
    check({tag, ".dn_req_up"}, dn_req, 1);
    check({tag, ".busy_up"}, busy, 1);
    check({tag, ".grant"}, grant_id, g);
    dn_ack = 1'b1;
    tick();
    check({tag, ".up_ack"}, up_ack, exp_ack);
    up_req[g] = 1'b0;
    tick();
    check({tag, ".dn_req_down"}, dn_req, 0);
    dn_ack = 1'b0;
    tick();
    check({tag, ".up_ack_down"}, up_ack, 0);
    check({tag, ".busy_down"}, busy, 0);
    check({tag, ".grant_hold"}, grant_id, g);
  endtask

  initial begin
    rst    = 1'b1;
    up_req = '0;
    dn_ack = 1'b0;
    tick();
    tick();
    check("rst.up_ack", up_ack, 0);
    check("rst.dn_req", dn_req, 0);
    check("rst.grant", grant_id, 0);
    check("rst.busy", busy, 0);
    check("rst.err", proto_err, 0);
    rst = 1'b0;

    // Single requester, downstream answering two cycles late.
    up_req = 4'b0001;
    tick();
    check("single.dn_req", dn_req, 1);
    check("single.grant", grant_id, 0);
    tick();
    check("single.wait_ack", up_ack, 0);
    dn_ack = 1'b1;
    tick();
    check("single.up_ack", up_ack, 4'b0001);
    up_req = 4'b0000;
    tick();
    check("single.dn_req_low", dn_req, 0);
    check("single.ack_held", up_ack, 4'b0001);
    tick();
    check("single.rtz_busy", busy, 1);
    dn_ack = 1'b0;
    tick();
    check("single.done_ack", up_ack, 0);
    check("single.done_busy", busy, 0);
    check("single.err", proto_err, 0);
    // ptr is now 1, so requester 1 beats requester 0.
    run_txn(4'b0011, 1, "ptr1");

    // All requesting from a fresh pointer: 0,1,2,3,0.
    do_reset();
    run_txn(4'b1111, 0, "all0");
    run_txn(4'b1111, 1, "all1");
    run_txn(4'b1111, 2, "all2");
    run_txn(4'b1111, 3, "all3");
    run_txn(4'b1111, 0, "all4");

    // Wrap and skip: bring ptr to 3, then 0101 -> 0, then 2.
    run_txn(4'b0100, 2, "skip_setup");
    run_txn(4'b0101, 0, "wrap");
    run_txn(4'b0101, 2, "skip");
    check("skip.err", proto_err, 0);

    // Spurious dn_ack in IDLE.
    do_reset();
    dn_ack = 1'b1;
    tick();
    check("spur.err", proto_err, 1);
    check("spur.up_ack", up_ack, 0);
    check("spur.busy", busy, 0);
    dn_ack = 1'b0;
    run_txn(4'b0001, 0, "spur_next");
    check("spur.err_sticky", proto_err, 1);

    // dn_ack dropped while in ACK: flagged, state unchanged.
    do_reset();
    up_req = 4'b0001;
    tick();
    dn_ack = 1'b1;
    tick();
    check("ackdrop.err_before", proto_err, 0);
    dn_ack = 1'b0;
    tick();
    check("ackdrop.err", proto_err, 1);
    check("ackdrop.up_ack", up_ack, 4'b0001);
    check("ackdrop.dn_req", dn_req, 1);
    up_req = 4'b0000;
    tick();
    check("ackdrop.rtz", dn_req, 0);
    tick();
    check("ackdrop.idle", busy, 0);

    // Withdrawal while in REQ.
    do_reset();
    up_req = 4'b0010;
    tick();
    check("wd.grant", grant_id, 1);
    up_req = 4'b0000;
    tick();
    check("wd.err", proto_err, 1);
    check("wd.dn_req", dn_req, 1);
    dn_ack = 1'b1;
    tick();
    check("wd.up_ack", up_ack, 4'b0010);
    check("wd.dn_req_ack", dn_req, 1);
    tick();
    check("wd.rtz", dn_req, 0);
    dn_ack = 1'b0;
    tick();
    check("wd.busy", busy, 0);
    check("wd.err_sticky", proto_err, 1);

    // Reset while in ACK (ptr is 2, only requester 3 asks).
    up_req = 4'b1000;
    tick();
    check("rstack.grant", grant_id, 3);
    dn_ack = 1'b1;
    tick();
    check("rstack.up_ack", up_ack, 4'b1000);
    rst = 1'b1;
    tick();
    check("rstack.up_ack0", up_ack, 0);
    check("rstack.dn_req0", dn_req, 0);
    check("rstack.busy0", busy, 0);
    check("rstack.err0", proto_err, 0);
    check("rstack.grant0", grant_id, 0);
    rst    = 1'b0;
    up_req = 4'b0000;
    dn_ack = 1'b0;
    tick();
    run_txn(4'b0100, 2, "after_rst");
    check("after_rst.err", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
